// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg: shared state encoding for the burst controller
package mem_burst_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ} mem_burst_state_e;
endpackage

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst initiator moving a valid/ready write stream into memory and memory out to a valid/ready read stream
module mem_burst_ctrl
  import mem_burst_pkg::*;
#(
  parameter int ElemWidth = 8,
  parameter int AddrWidth = 8,
  parameter int LenWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_write_i,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [LenWidth-1:0]  cmd_len_i,
  input  logic [ElemWidth-1:0] wdata_i,
  input  logic                 wdata_valid_i,
  output logic                 wdata_ready_o,
  output logic [ElemWidth-1:0] rdata_o,
  output logic                 rdata_valid_o,
  input  logic                 rdata_ready_i,
  output logic                 done_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [ElemWidth-1:0] mem_wdata_o,
  input  logic [ElemWidth-1:0] mem_rdata_i
);
  mem_burst_state_e     state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [LenWidth-1:0]  cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 beat;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    beat    = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        addr_d  = cmd_addr_i;
        cnt_d   = cmd_len_i;
        state_d = cmd_write_i ? WRITE : READ;
      end
      WRITE:   beat = wdata_valid_i;
      READ:    beat = rdata_ready_i;
      default: state_d = IDLE;
    endcase
    if (beat) begin
      addr_d = addr_q + 1'b1;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end
  assign cmd_ready_o   = state_q == IDLE;
  assign wdata_ready_o = state_q == WRITE;
  assign rdata_valid_o = state_q == READ;
  assign mem_we_o      = (state_q == WRITE) && wdata_valid_i;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_i;
  assign rdata_o       = mem_rdata_i;
  assign done_o        = done_q;
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: scoreboard bench for mem_burst_ctrl with an async-read, sync-write memory attached
module tb_mem_burst_ctrl;
  logic       clk_i = 1'b0;
  logic       arst_ni = 1'b0;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic       cmd_write_i = 1'b0;
  logic [7:0] cmd_addr_i = '0;
  logic [7:0] cmd_len_i = '0;
  logic [7:0] wdata_i = '0;
  logic       wdata_valid_i = 1'b0;
  logic       wdata_ready_o;
  logic [7:0] rdata_o;
  logic       rdata_valid_o;
  logic       rdata_ready_i = 1'b0;
  logic       done_o;
  logic       mem_we_o;
  logic [7:0] mem_addr_o;
  logic [7:0] mem_wdata_o;
  logic [7:0] mem_rdata_i;
  logic [7:0] mem [256];
  logic [7:0] model [256];
  logic [15:0] wq[$];
  logic [15:0] rq[$];
  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  logic       stalled = 1'b0;
  logic [15:0] stall_val;
  always #5 clk_i = ~clk_i;
  mem_burst_ctrl dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i),
    .done_o(done_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );
  assign mem_rdata_i = mem[mem_addr_o];
  always @(posedge clk_i) if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk_i) if (arst_ni) begin
    if (mem_we_o) begin
      we_cnt++;
      chk("write_expected", 32'(wq.size() > 0), 32'd1);
      if (wq.size() > 0) chk("write_addr_data", {mem_addr_o, mem_wdata_o}, wq.pop_front());
    end
    if (rdata_valid_o) begin
      if (stalled) chk("stall_hold", {mem_addr_o, rdata_o}, stall_val);
      stalled   = !rdata_ready_i;
      stall_val = {mem_addr_o, rdata_o};
      if (rdata_ready_i) begin
        chk("read_expected", 32'(rq.size() > 0), 32'd1);
        if (rq.size() > 0) chk("read_addr_data", {mem_addr_o, rdata_o}, rq.pop_front());
      end
    end else stalled = 1'b0;
    if (done_o) done_cnt++;
  end
  task automatic do_cmd(input logic w, input logic [7:0] a, input logic [7:0] l);
    @(posedge clk_i); #1;
    chk("cmd_ready_idle", cmd_ready_o, 1);
    cmd_valid_i = 1'b1; cmd_write_i = w; cmd_addr_i = a; cmd_len_i = l;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0; cmd_write_i = ~w; cmd_addr_i = 8'hEE; cmd_len_i = 8'h55;
  endtask
  task automatic chk_done(input int dc);
    chk("done_pulse", done_o, 1);
    chk("cmd_ready_after", cmd_ready_o, 1);
    @(posedge clk_i); #1;
    chk("done_one_cycle", done_o, 0);
    chk("done_count", 32'(done_cnt - dc), 1);
  endtask
  task automatic wr(input logic [7:0] a, input int n, input logic [7:0] d0, input logic [15:0] pat, output int cyc);
    int k = 0;
    int dc;
    for (int j = 0; j < n; j++) begin
      wq.push_back({a + 8'(j), d0 + 8'(j)});
      model[a + 8'(j)] = d0 + 8'(j);
    end
    do_cmd(1'b1, a, 8'(n - 1));
    dc = done_cnt;
    cyc = 0;
    while (k < n && cyc < 64) begin
      wdata_valid_i = pat[cyc % 16];
      wdata_i = wdata_valid_i ? d0 + 8'(k) : 8'hXX;
      @(negedge clk_i);
      if (wdata_valid_i && wdata_ready_o) k++;
      @(posedge clk_i); #1;
      cyc++;
    end
    wdata_valid_i = 1'b0;
    chk("write_beats", k, n);
    chk_done(dc);
  endtask
  task automatic rd(input logic [7:0] a, input int n, input logic [15:0] pat, output int cyc);
    int k = 0;
    int dc;
    for (int j = 0; j < n; j++) rq.push_back({a + 8'(j), model[a + 8'(j)]});
    do_cmd(1'b0, a, 8'(n - 1));
    dc = done_cnt;
    cyc = 0;
    while (k < n && cyc < 64) begin
      rdata_ready_i = pat[cyc % 16];
      @(negedge clk_i);
      if (rdata_valid_o && rdata_ready_i) k++;
      @(posedge clk_i); #1;
      cyc++;
    end
    rdata_ready_i = 1'b0;
    chk("read_beats", k, n);
    chk_done(dc);
  endtask
  initial begin
    int cyc;
    int wb;
    int dc;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      model[i] = 8'h00;
    end
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_wdata_ready", wdata_ready_o, 0);
    chk("rst_rdata_valid", rdata_valid_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_done", done_o, 0);
    arst_ni = 1'b1;
    wr(8'h10, 4, 8'hA0, 16'hFFFF, cyc);
    chk("wr_cycles", cyc, 4);
    for (int i = 0; i < 4; i++) chk("mem_10", mem[8'h10 + 8'(i)], 8'hA0 + 8'(i));
    rd(8'h10, 4, 16'hFFFF, cyc);
    chk("rd_consecutive", cyc, 4);
    rd(8'h10, 4, 16'h0069, cyc);
    chk("rd_stall_cycles", cyc, 7);
    wr(8'hFE, 4, 8'hC0, 16'hFFFF, cyc);
    chk("wrap_fe", mem[8'hFE], 8'hC0);
    chk("wrap_ff", mem[8'hFF], 8'hC1);
    chk("wrap_00", mem[8'h00], 8'hC2);
    chk("wrap_01", mem[8'h01], 8'hC3);
    chk("wrap_02_untouched", mem[8'h02], 8'h00);
    wb = we_cnt;
    wr(8'h20, 4, 8'hD0, 16'h0035, cyc);
    chk("gap_we_cycles", 32'(we_cnt - wb), 4);
    chk("gap_cycles", cyc, 6);
    for (int i = 0; i < 4; i++) chk("mem_20", mem[8'h20 + 8'(i)], 8'hD0 + 8'(i));
    wq.push_back({8'h40, 8'hB0});
    wq.push_back({8'h41, 8'hB1});
    do_cmd(1'b1, 8'h40, 8'd3);
    dc = done_cnt;
    for (int i = 0; i < 2; i++) begin
      wdata_valid_i = 1'b1;
      wdata_i = 8'hB0 + 8'(i);
      @(posedge clk_i); #1;
    end
    wdata_i = 8'hB2;
    arst_ni = 1'b0;
    #1;
    chk("abort_cmd_ready", cmd_ready_o, 1);
    chk("abort_mem_we", mem_we_o, 0);
    chk("abort_wdata_ready", wdata_ready_o, 0);
    chk("abort_done", done_o, 0);
    @(posedge clk_i); #1;
    wdata_valid_i = 1'b0;
    arst_ni = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("abort_no_done", 32'(done_cnt - dc), 0);
    chk("abort_mem_40", mem[8'h40], 8'hB0);
    chk("abort_mem_41", mem[8'h41], 8'hB1);
    chk("abort_mem_42", mem[8'h42], 8'h00);
    chk("abort_mem_43", mem[8'h43], 8'h00);
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
